aes_cipher_iter: RTL and testbench
==================================

# aes_cipher_iter

Iterative AES encryption core that sits directly downstream of the key-expansion stage. It consumes the full expanded key schedule as one flat bus and a 128-bit plaintext block, then runs one AES round per clock. It returns the 128-bit ciphertext with a single-cycle completion pulse. N, Nr and Nk together select AES-128, AES-192 or AES-256.

## Interface
- `N`, default 128: key length in bits; 128, 192 or 256. Carried for consistency with key expansion only; unused internally.
- `Nr`, default 10: number of rounds; 10, 12 or 14.
- `Nk`, default 4: key length in 32-bit words; 4, 6 or 8. Carried for consistency only.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to encrypt `in`; sampled only in IDLE.
- `in`  in  [0:127]  plaintext. Byte b is `in[8b+:8]`; bit 0 is the MSB. Bytes map column-major to the state per FIPS-197.
- `words`  in  [0:128*(Nr+1)-1]  round-key schedule. Round key r is `words[128r+:128]`. Same ordering as the key-expansion output.
- `out`  out  [0:127]  ciphertext, same byte ordering as `in`.
- `busy`  out  1  high from the cycle after start acceptance until the done cycle, inclusive.
- `done`  out  1  one-cycle pulse; `out` is valid from this cycle on.

## Operation
- FSM states:
  - IDLE → BUSY on `start`=1.
  - BUSY → DONE when the round counter equals Nr.
  - DONE → IDLE unconditionally.
- Start acceptance (IDLE, `start`=1):
  - state ← `in` ^ round key 0.
  - round ← 1.
- Each BUSY cycle:
  - state ← AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), key[round]); round ← round+1.
  - In the round == Nr cycle, MixColumns is skipped and the result is written to `out` instead of `state`.
- DONE: `done`=1 for exactly one cycle.
- `start` is ignored in BUSY and DONE; there is no queueing. A `start` held high through DONE is accepted in the next IDLE cycle.
- `in` is sampled only at acceptance. `words` must stay stable from acceptance through DONE, because round keys are read live and not latched.
- `out` holds its value until the next completion overwrites it. It is never cleared between operations.
- Round counter width: 4 bits, covering 0..14.
- MixColumns uses xtime over GF(2^8), polynomial 0x11B.

## Timing
- Reset values: `out`=0, `done`=0, `busy`=0, state register=0, round=0, FSM=IDLE.
- Reset mid-operation aborts immediately. No `done` is produced and the engine accepts a new `start` on the first cycle after `rst_n` deasserts.
- Latency:
  - `start` sampled at edge 0.
  - BUSY spans edges 1..Nr.
  - `done` is high in the cycle following edge Nr+1.
  - Total: Nr+1 cycles from acceptance to `done` (11 / 13 / 15).
- Throughput: one block per Nr+2 cycles when `start` is held high.
- `busy` and `done` are registered outputs and never both 0 during an operation.

## Structure
- Shared package `aes_pkg`, also used by key expansion:
  - `sbox` function (256-entry table).
  - `xtime` function.
  - block width constant 128.
  - FSM state typedef `{IDLE, BUSY, DONE}`.
- One combinational sub-module, `aes_round`:
  - inputs: state[0:127], key[0:127], `last`.
  - output: next state. SubBytes, ShiftRows, conditional MixColumns, AddRoundKey.
- The top level holds only the FSM, round counter, state register and output register.

## Test plan
- AES-128 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → `out`=3925841d02dc09fbdc118597196a0b32, `done` exactly 11 cycles after acceptance.
- AES-128 App. C.1: key 000102…0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a.
- Nr=12/Nk=6 key 000102…17 → dda97ca4864cdfe06eaf70a0ec0d7191 after 13 cycles. Nr=14/Nk=8 key 000102…1f → 8ea2b7ca516745bfeafc49904b496089 after 15 cycles.
- Pulse `start` again while BUSY with a different `in`: ignored; first ciphertext unchanged and only one `done` pulse. With `start` held high continuously, back-to-back blocks complete every Nr+2 cycles.
- Assert `rst_n`=0 at round 5:
  - `out`/`done`/`busy` go to 0 immediately and no `done` follows.
  - After release, a fresh App. C.1 run gives the correct ciphertext.
- After completion, hold `start`=0 for 20 cycles: `out` remains 69c4e0d8… and `done` stays 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES helpers for key expansion and the cipher core: S-box, xtime,
// block width and the cipher FSM state type.
package aes_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[8*(255 - int'(x)) +: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped when
// last is set) and AddRoundKey. Byte b of a block is bits [8b +: 8], column-major.
module aes_round
  import aes_pkg::*;
(
  input  logic [0:BLOCK_W-1] state,
  input  logic [0:BLOCK_W-1] key,
  input  logic               last,
  output logic [0:BLOCK_W-1] next_state
);

  logic [0:BLOCK_W-1] w_sr;
  logic [0:BLOCK_W-1] w_mc;

  // Row r of column c is taken from column (c + r) mod 4 of the same row.
  function automatic int shift_src(input int b);
    return 4 * (((b / 4) + (b % 4)) % 4) + (b % 4);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  always_comb begin
    // NOTE: give every combinational output a default before the loops so no
    // path can leave it unassigned and infer a latch.
    w_sr = '0;
    for (int b = 0; b < 16; b++) begin
      w_sr[8*b +: 8] = sbox(state[8*shift_src(b) +: 8]);
    end
  end

  always_comb begin
    w_mc = '0;
    for (int c = 0; c < 4; c++) begin
      w_mc[32*c +: 32] = last ? w_sr[32*c +: 32] : mix_col(w_sr[32*c +: 32]);
    end
  end

  assign next_state = w_mc ^ key;

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core: one round per clock against a live expanded
// key schedule; ciphertext is reported with a one-cycle done pulse.
module aes_cipher_iter
  import aes_pkg::*;
#(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [0:BLOCK_W-1]        in,
  input  logic [0:BLOCK_W*(Nr+1)-1] words,
  output logic [0:BLOCK_W-1]        out,
  output logic                      busy,
  output logic                      done
);

  localparam logic [3:0] LAST_ROUND = 4'(Nr);

  if (N != 32 * Nk || Nr != Nk + 6) begin : g_bad_cfg
    $error("aes_cipher_iter: N, Nk and Nr do not describe one AES variant");
  end

  aes_state_e         r_fsm, w_fsm_nxt;
  logic [3:0]         r_round;
  logic [0:BLOCK_W-1] r_state, r_out;
  logic [0:BLOCK_W-1] w_round_key, w_round_out;
  logic               r_busy, r_done;
  logic               w_busy_nxt, w_done_nxt;
  logic               w_accept, w_last;

  assign w_accept = (r_fsm == IDLE) && start;
  assign w_last   = (r_round == LAST_ROUND);
  // The schedule is not latched; the key-expansion side holds it steady until done.
  assign w_round_key = words[BLOCK_W*int'(r_round) +: BLOCK_W];

  aes_round u_round (
    .state      (r_state),
    .key        (w_round_key),
    .last       (w_last),
    .next_state (w_round_out)
  );

  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (r_fsm)
      IDLE: begin
        if (start) begin
          w_fsm_nxt  = BUSY;
          w_busy_nxt = 1'b1;
        end
      end
      BUSY: begin
        w_busy_nxt = 1'b1;
        if (w_last) w_fsm_nxt = DONE;
      end
      DONE: begin
        w_busy_nxt = 1'b1;
        w_done_nxt = 1'b1;
        w_fsm_nxt  = IDLE;
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm  <= IDLE;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_fsm  <= w_fsm_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_out   <= '0;
      r_round <= '0;
    end else if (w_accept) begin
      r_state <= in ^ words[0 +: BLOCK_W];
      r_round <= 4'd1;
    end else if (r_fsm == BUSY) begin
      r_round <= r_round + 4'd1;
      if (w_last) r_out   <= w_round_out;
      else        r_state <= w_round_out;
    end
  end

  assign out  = r_out;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Scoreboard bench for aes_cipher_iter: AES-128/192/256 instances checked against
// a reference AES built from GF(2^8) arithmetic, with an independent done monitor.
module tb_aes_cipher_iter;

  typedef struct packed {
    logic [127:0] ct;
    int           done_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   start_v;
  logic [2:0]   busy_v;
  logic [2:0]   done_v;
  logic [127:0] pt_v [3];
  logic [0:1407] words0;
  logic [0:1663] words1;
  logic [0:1919] words2;
  logic [127:0] out0, out1, out2;
  exp_t         q0[$], q1[$], q2[$];
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  logic [7:0]   sb [256];

  localparam logic [0:255] KEY_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [0:255] KEY_C1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [0:255] KEY_192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [0:255] KEY_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_cipher_iter #(.N(128), .Nr(10), .Nk(4)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in(pt_v[0]), .words(words0),
    .out(out0), .busy(busy_v[0]), .done(done_v[0]));
  aes_cipher_iter #(.N(192), .Nr(12), .Nk(6)) u_dut192 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in(pt_v[1]), .words(words1),
    .out(out1), .busy(busy_v[1]), .done(done_v[1]));
  aes_cipher_iter #(.N(256), .Nr(14), .Nk(8)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in(pt_v[2]), .words(words2),
    .out(out2), .busy(busy_v[2]), .done(done_v[2]));

  function automatic int nr_of(input int idx);
    return 10 + 2 * idx;
  endfunction

  function automatic int nk_of(input int idx);
    return 4 + 2 * idx;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box = affine transform of the multiplicative inverse.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [0:1919] expand(input logic [0:255] key, input int nk, input int nr);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1919] res;
    rc  = 8'h01;
    res = '0;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 4 * (nr + 1); i++) res[32*i +: 32] = w[i];
    return res;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [0:1919] w, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] res;
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[8*b +: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int b = 0; b < 16; b++) t[b] = sb[s[b]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd < nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) t[r] = s[4*c+r];
          for (int r = 0; r < 4; r++)
            s[4*c+r] = gmul(t[r], 8'h02) ^ gmul(t[(r+1)%4], 8'h03) ^ t[(r+2)%4] ^ t[(r+3)%4];
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[128*rnd + 8*b +: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int idx, input logic [127:0] ct, input int dc);
    exp_t e;
    e.ct       = ct;
    e.done_cyc = dc;
    case (idx)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int idx, input logic [127:0] o, input logic b);
    exp_t e;
    int   n;
    e = '0;
    case (idx)
      0:       n = q0.size();
      1:       n = q1.size();
      default: n = q2.size();
    endcase
    check($sformatf("done%0d_was_expected", idx), 128'(n > 0), 128'(1));
    if (n > 0) begin
      case (idx)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check($sformatf("ciphertext%0d", idx), o, e.ct);
      check($sformatf("done_cycle%0d", idx), 128'(cyc), 128'(e.done_cyc));
      check($sformatf("busy_at_done%0d", idx), 128'(b), 128'(1));
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_v[i]) mon(i, (i == 0) ? out0 : (i == 1) ? out1 : out2, busy_v[i]);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [127:0] out_of(input int idx);
    return (idx == 0) ? out0 : (idx == 1) ? out1 : out2;
  endfunction

  task automatic set_words(input int idx, input logic [0:1919] w);
    case (idx)
      0:       words0 = w[0:1407];
      1:       words1 = w[0:1663];
      default: words2 = w;
    endcase
  endtask

  // Acceptance happens at the next rising edge; done is due Nr+1 edges later.
  task automatic run_block(input int idx, input logic [127:0] pt, input logic [127:0] ct);
    @(negedge clk);
    pt_v[idx]    = pt;
    start_v[idx] = 1'b1;
    push(idx, ct, cyc + nr_of(idx) + 2);
    @(negedge clk);
    start_v[idx] = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 128'(q0.size() + q1.size() + q2.size()), 128'(0));
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [0:1919] w;
    logic [0:255]  key;
    logic [127:0]  pt;

    build_sbox();
    rst_n   = 1'b0;
    start_v = '0;
    for (int i = 0; i < 3; i++) pt_v[i] = '0;
    words0 = '0;
    words1 = '0;
    words2 = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_out%0d", i), out_of(i), 128'(0));
      check($sformatf("reset_busy%0d", i), 128'(busy_v[i]), 128'(0));
      check($sformatf("reset_done%0d", i), 128'(done_v[i]), 128'(0));
    end
    rst_n = 1'b1;

    // Published vectors.
    set_words(0, expand(KEY_B, 4, 10));
    run_block(0, PT_B, CT_B);
    drain(40);
    set_words(0, expand(KEY_C1, 4, 10));
    run_block(0, PT_C, CT_C1);
    drain(40);
    set_words(1, expand(KEY_192, 6, 12));
    run_block(1, PT_C, CT_192);
    drain(40);
    set_words(2, expand(KEY_256, 8, 14));
    run_block(2, PT_C, CT_256);
    drain(40);

    // Random keys and plaintexts against the reference model.
    for (int idx = 0; idx < 3; idx++) begin
      for (int k = 0; k < 3; k++) begin
        key = {rand128(), rand128()};
        w   = expand(key, nk_of(idx), nr_of(idx));
        set_words(idx, w);
        pt = rand128();
        run_block(idx, pt, encrypt(pt, w, nr_of(idx)));
        drain(40);
      end
    end

    // A start pulse during BUSY is dropped; output then holds while idle.
    set_words(0, expand(KEY_C1, 4, 10));
    run_block(0, PT_C, CT_C1);
    repeat (3) @(negedge clk);
    pt_v[0]    = rand128();
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    drain(40);
    repeat (20) begin
      @(negedge clk);
      check("hold_out", out0, CT_C1);
      check("hold_done", 128'(done_v[0]), 128'(0));
    end

    // start held high: one block every Nr+2 cycles.
    key = {rand128(), rand128()};
    w   = expand(key, 6, 12);
    set_words(1, w);
    @(negedge clk);
    start_v[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pt      = rand128();
      pt_v[1] = pt;
      push(1, encrypt(pt, w, 12), cyc + 14);
      if (k < 2) repeat (14) @(negedge clk);
      else       @(negedge clk);
    end
    start_v[1] = 1'b0;
    drain(60);

    // Reset at round 5 aborts; a start right at release is accepted.
    @(negedge clk);
    pt_v[0]    = PT_C;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_mid_run", 128'(busy_v[0]), 128'(1));
    #1 rst_n = 1'b0;
    #1;
    check("abort_out", out0, 128'(0));
    check("abort_done", 128'(done_v[0]), 128'(0));
    check("abort_busy", 128'(busy_v[0]), 128'(0));
    repeat (2) @(negedge clk);
    pt_v[0]    = PT_C;
    start_v[0] = 1'b1;
    rst_n      = 1'b1;
    push(0, CT_C1, cyc + 12);
    @(negedge clk);
    start_v[0] = 1'b0;
    drain(40);

    repeat (20) @(negedge clk);
    check("final_queue_empty", 128'(q0.size() + q1.size() + q2.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
